// File: rtl/sram_ext_pkg.sv
// Shared definitions for the external-SRAM loader: FSM states, command codes and SRAM op encoding.
package sram_ext_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_DUMP_RD  = 3'd2,
        ST_DUMP_OUT = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic CMD_LOAD = 1'b0;
    localparam logic CMD_DUMP = 1'b1;

    // SRAM operation as {wen, ren}; 2'b11 is never produced.
    localparam logic [1:0] SRAM_OP_IDLE  = 2'b00;
    localparam logic [1:0] SRAM_OP_WRITE = 2'b10;
    localparam logic [1:0] SRAM_OP_READ  = 2'b01;

    function automatic int unsigned bytes_per_word(input int unsigned bw);
        return bw / 8;
    endfunction

endpackage

// File: rtl/sram_ext_addr_gen.sv
// Address/count generator: latches base and word count, steps by one word with
// wrap modulo 2**ADDR_W, and flags the last remaining word.
module sram_ext_addr_gen
    import sram_ext_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int BW     = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_cnt,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(bytes_per_word(BW));
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;

    // The natural overflow of the ADDR_W-bit adder provides the wrap.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_cnt;
        end else if (i_step) begin
            r_addr      <= r_addr + STEP;
            r_remaining <= r_remaining - ONE;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == ONE);

endmodule

// File: rtl/sram_ext_loader.sv
// Streams words into (LOAD) or out of (DUMP) an external SRAM port.
// Optional XOR checksum output when LOADER_CHECKSUM_EN is defined.
module sram_ext_loader
    import sram_ext_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int BW     = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              cmd,
    input  logic [63:0]       base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BW-1:0]     m_data,
    output logic [63:0]       sram_addr,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic [BW-1:0]     sram_wdata,
    input  logic [BW-1:0]     sram_rdata
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [BW-1:0]     checksum
`endif
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_step;
    logic [1:0]        w_sram_op;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic [BW-1:0]     r_m_data;
    logic              w_unused_base;

    // Only the low ADDR_W address bits reach the SRAM.
    assign w_unused_base = ^base_addr[63:ADDR_W];
    assign w_accept      = start && (r_state == ST_IDLE);

    sram_ext_addr_gen #(
        .ADDR_W (ADDR_W),
        .BW     (BW)
    ) u_addr_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .i_load (w_accept),
        .i_base (base_addr[ADDR_W-1:0]),
        .i_cnt  (word_cnt),
        .i_step (w_step),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sram_op    = SRAM_OP_IDLE;
        w_step       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (word_cnt == '0) begin
                        w_state_next = ST_DONE;
                    end else if (cmd == CMD_LOAD) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_DUMP_RD;
                    end
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_sram_op = SRAM_OP_WRITE;
                    w_step    = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DUMP_RD: begin
                w_sram_op    = SRAM_OP_READ;
                w_state_next = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_step       = 1'b1;
                    w_state_next = w_last ? ST_DONE : ST_DUMP_RD;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Read data is captured at the end of the read cycle and held through DUMP_OUT.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_m_data <= '0;
        end else if (r_state == ST_DUMP_RD) begin
            r_m_data <= sram_rdata;
        end
    end

    assign m_data     = r_m_data;
    assign sram_wen   = w_sram_op[1];
    assign sram_ren   = w_sram_op[0];
    assign sram_wdata = sram_wen ? s_data : '0;
    assign sram_addr  = {{(64 - ADDR_W){1'b0}}, w_addr};

`ifdef LOADER_CHECKSUM_EN
    logic [BW-1:0] r_checksum;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (sram_wen) begin
            r_checksum <= r_checksum ^ s_data;
        end else if ((r_state == ST_DUMP_OUT) && m_ready) begin
            r_checksum <= r_checksum ^ r_m_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_sram_ext_loader.sv
// Bench for sram_ext_loader: directed table, hand-written reset sequence and
// randomized transfers checked against a word-level memory model.
module tb_sram_ext_loader;
    import sram_ext_pkg::*;

    localparam int ADDR_W = 9;
    localparam int BW     = 32;

    logic              clk;
    logic              arst_n;
    logic              start;
    logic              cmd;
    logic [63:0]       base_addr;
    logic [ADDR_W-1:0] word_cnt;
    logic              busy;
    logic              done;
    logic              s_valid;
    logic              s_ready;
    logic [BW-1:0]     s_data;
    logic              m_valid;
    logic              m_ready;
    logic [BW-1:0]     m_data;
    logic [63:0]       sram_addr;
    logic              sram_wen;
    logic              sram_ren;
    logic [BW-1:0]     sram_wdata;
    logic [BW-1:0]     sram_rdata;
`ifdef LOADER_CHECKSUM_EN
    logic [BW-1:0]     checksum;
`endif

    sram_ext_loader #(.ADDR_W(ADDR_W), .BW(BW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .cmd        (cmd),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_ren   (sram_ren),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM: 128 words, combinational read, write on the rising edge.
    logic [31:0] mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (sram_wen) mem[sram_addr[8:2]] <= sram_wdata;
        end
    end
    assign sram_rdata = mem[sram_addr[8:2]];

    // Reference model: what the memory should hold, word-indexed.
    logic [31:0] ref_mem [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Observed traffic, sampled mid-cycle.
    logic [63:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [63:0] rd_addr_q[$];
    logic [31:0] out_q[$];
    int          done_cnt = 0;
    int          viol     = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_m_data = '0;

    always @(negedge clk) begin
        if (sram_wen) begin
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_wdata);
        end
        if (sram_ren) rd_addr_q.push_back(sram_addr);
        if (m_valid && m_ready) out_q.push_back(m_data);
        if (done) done_cnt++;
        if (sram_wen && sram_ren) viol++;
        if ((sram_wen || sram_ren) && (sram_addr[63:9] != '0)) viol++;
        if (prev_stall && (!m_valid || (m_data != prev_m_data))) viol++;
        prev_stall  = m_valid && !m_ready;
        prev_m_data = m_data;
    end

    logic [31:0] xfer_data[$];
    int          last_done_cyc;
    bit          last_got;
    logic [31:0] cs_at_done;
    int          xfer_no = 0;

    task automatic drive(input logic c, input logic [63:0] b, input int n, input int bp,
                         input bit rnd, input bit poke);
        int idx     = 0;
        int bp_left = bp;
        int cyc     = 0;
        last_got      = 0;
        last_done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; cmd = c; base_addr = b; word_cnt = 9'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        cmd       = ~c;
        base_addr = {$urandom, $urandom};
        word_cnt  = 9'($urandom_range(1, 511));
        while (!last_got && cyc < 200) begin
            start   = poke && (cyc == 1);
            s_valid = (c == CMD_LOAD) && (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
            s_data  = (s_valid) ? xfer_data[idx] : $urandom;
            m_ready = (c == CMD_DUMP) && (bp_left == 0) && (!rnd || $urandom_range(0, 2) != 0);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (m_valid && !m_ready && bp_left > 0) bp_left--;
            if (done) begin
                last_got      = 1;
                last_done_cyc = cyc;
`ifdef LOADER_CHECKSUM_EN
                cs_at_done = checksum;
`endif
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic run_xfer(input logic c, input logic [63:0] b, input int n, input int bp,
                            input bit rnd, input bit poke);
        int          d0     = done_cnt;
        logic [31:0] exp_cs = '0;
        logic [63:0] exp_a;
        int          widx;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); out_q.delete();
        drive(c, b, n, bp, rnd, poke);
        repeat (2) @(posedge clk);
        #1;
        check("done_seen", 64'(last_got), 64'd1);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        if (c == CMD_LOAD) begin
            check("wr_count", 64'(wr_addr_q.size()), 64'(n));
            check("rd_count", 64'(rd_addr_q.size()), 64'd0);
        end else begin
            check("wr_count", 64'(wr_addr_q.size()), 64'd0);
            check("rd_count", 64'(rd_addr_q.size()), 64'(n));
            check("out_count", 64'(out_q.size()), 64'(n));
        end
        for (int i = 0; i < n; i++) begin
            exp_a = (b + 64'(4 * i)) % 64'd512;
            widx  = int'(exp_a >> 2);
            if (c == CMD_LOAD) begin
                if (i < wr_addr_q.size()) begin
                    check("wr_addr", wr_addr_q[i], exp_a);
                    check("wr_data", 64'(wr_data_q[i]), 64'(xfer_data[i]));
                end
                ref_mem[widx] = xfer_data[i];
                exp_cs ^= xfer_data[i];
            end else begin
                if (i < rd_addr_q.size()) check("rd_addr", rd_addr_q[i], exp_a);
                if (i < out_q.size()) check("m_data", 64'(out_q[i]), 64'(ref_mem[widx]));
                exp_cs ^= ref_mem[widx];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        check("checksum", 64'(cs_at_done), 64'(exp_cs));
`endif
        $display("xfer %0d: %s base=0x%03h cnt=%0d done_cycle=%0d writes=%0d reads=%0d",
                 xfer_no, (c == CMD_LOAD) ? "LOAD" : "DUMP", b, n, last_done_cyc,
                 wr_addr_q.size(), rd_addr_q.size());
        xfer_no++;
    endtask

    typedef struct {
        logic        c;
        logic [63:0] base;
        int          cnt;
        logic [31:0] dat0;
        logic [31:0] dxor;
        int          bp;
        bit          poke;
        int          exp_done;
        logic [63:0] exp_first_addr;
        logic [63:0] exp_last_addr;
        logic [31:0] exp_first_word;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d0;
        logic [63:0] first_a, last_a;
        logic [31:0] first_w;

        vecs[0] = '{CMD_LOAD, 64'h000, 4, 32'hA0, 32'h01, 0, 0, 4, 64'h000, 64'h00C, 32'hA0};
        vecs[1] = '{CMD_DUMP, 64'h004, 2, 32'h00, 32'h00, 3, 0, 7, 64'h004, 64'h008, 32'hA1};
        vecs[2] = '{CMD_LOAD, 64'h1FC, 2, 32'h55, 32'h11, 0, 0, 2, 64'h1FC, 64'h000, 32'h55};
        vecs[3] = '{CMD_LOAD, 64'h040, 0, 32'h00, 32'h00, 0, 0, 0, 64'h000, 64'h000, 32'h00};
        vecs[4] = '{CMD_LOAD, 64'h100, 2, 32'h0F, 32'hFF, 0, 1, 2, 64'h100, 64'h104, 32'h0F};
        vecs[5] = '{CMD_DUMP, 64'h1FC, 2, 32'h00, 32'h00, 0, 0, 4, 64'h1FC, 64'h000, 32'h55};
        vecs[6] = '{CMD_DUMP, 64'h010, 0, 32'h00, 32'h00, 0, 0, 0, 64'h000, 64'h000, 32'h00};

        for (int i = 0; i < 128; i++) ref_mem[i] = '0;

        // Reset with busy inputs: every output must still be zero.
        arst_n = 1'b0; start = 1'b1; cmd = CMD_LOAD; base_addr = 64'h1F0; word_cnt = 9'd3;
        s_valid = 1'b1; s_data = 32'hFFFF_FFFF; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, s_ready, m_valid, sram_wen, sram_ren}), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_sram_addr", sram_addr, 64'd0);
        check("rst_wdata", 64'(sram_wdata), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; arst_n = 1'b1;

        for (int r = 0; r < 7; r++) begin
            xfer_data.delete();
            for (int i = 0; i < vecs[r].cnt; i++)
                xfer_data.push_back(vecs[r].dat0 ^ (vecs[r].dxor * 32'(i)));
            run_xfer(vecs[r].c, vecs[r].base, vecs[r].cnt, vecs[r].bp, 0, vecs[r].poke);
            check("done_cycle", 64'(last_done_cyc), 64'(vecs[r].exp_done));
            if (vecs[r].cnt > 0) begin
                first_a = (vecs[r].c == CMD_LOAD) ? wr_addr_q[0] : rd_addr_q[0];
                last_a  = (vecs[r].c == CMD_LOAD) ? wr_addr_q[wr_addr_q.size() - 1]
                                                  : rd_addr_q[rd_addr_q.size() - 1];
                first_w = (vecs[r].c == CMD_LOAD) ? wr_data_q[0] : out_q[0];
                check("first_addr", first_a, vecs[r].exp_first_addr);
                check("last_addr", last_a, vecs[r].exp_last_addr);
                check("first_word", 64'(first_w), 64'(vecs[r].exp_first_word));
            end
        end

        // Reset after two of eight words: abandoned, no done, then a clean restart.
        xfer_data.delete();
        for (int i = 0; i < 8; i++) xfer_data.push_back($urandom);
        wr_addr_q.delete(); wr_data_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cmd = CMD_LOAD; base_addr = 64'h080; word_cnt = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = xfer_data[i];
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = xfer_data[2]; m_ready = 1'b1;
        #2 arst_n = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", 64'({busy, done, s_ready, m_valid, sram_wen, sram_ren}), 64'd0);
        check("midrst_m_data", 64'(m_data), 64'd0);
        check("midrst_addr", sram_addr, 64'd0);
        check("midrst_wdata", 64'(sram_wdata), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0; m_ready = 1'b0; arst_n = 1'b1;
        check("midrst_writes", 64'(wr_addr_q.size()), 64'd2);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        ref_mem[32] = xfer_data[0];
        ref_mem[33] = xfer_data[1];
        $display("xfer %0d: LOAD base=0x080 cnt=8 abandoned by reset after %0d writes",
                 xfer_no, wr_addr_q.size());
        xfer_no++;

        xfer_data.delete();
        xfer_data.push_back(32'h1234_5678);
        run_xfer(CMD_LOAD, 64'h0F0, 1, 0, 0, 0);
        check("post_rst_done_cycle", 64'(last_done_cyc), 64'd1);
        run_xfer(CMD_DUMP, 64'h080, 2, 0, 0, 0);

        // Randomized transfers against the memory model.
        for (int t = 0; t < 24; t++) begin
            logic        c;
            logic [63:0] b;
            int          n;
            c = 1'($urandom_range(0, 1));
            b = 64'($urandom_range(0, 127)) << 2;
            n = $urandom_range(1, 10);
            xfer_data.delete();
            for (int i = 0; i < n; i++) xfer_data.push_back($urandom);
            run_xfer(c, b, n, 0, 1, 0);
        end

        check("protocol_violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_ext_loader.md
SRAM_EXT_LOADER -- requirements
Module: sram_ext_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning SRAM byte-address width.
REQ-002 SHALL have parameter BW, default 32, meaning data word width, 32 or 64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: command pulse, accepted only in IDLE.
REQ-006 SHALL have port cmd, input, 1 bit: 0=LOAD (stream to SRAM), 1=DUMP (SRAM to stream).
REQ-007 SHALL have port base_addr, input, 64 bits: first byte address, BW/8-aligned.
REQ-008 SHALL have port word_cnt, input, ADDR_W bits: number of words to transfer.
REQ-009 SHALL have ports busy and done, output, 1 bit each: transfer active; one-cycle completion pulse.
REQ-010 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, BW): the load stream.
REQ-011 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, BW): the dump stream.
REQ-012 SHALL have ports sram_addr (output, 64), sram_wen (output, 1), sram_ren (output, 1), sram_wdata (output, BW) and sram_rdata (input, BW), driving the external port of sram_BW32/sram_BW64.

Function
REQ-013 SHALL encode SRAM operations as: write = wen 1, ren 0; read = wen 0, ren 1; idle = both 0; wen=ren=1 SHALL never be driven.
REQ-014 SHALL implement the states IDLE, LOAD, DUMP_RD, DUMP_OUT and DONE.
REQ-015 On start in IDLE, SHALL latch base_addr, word_cnt and cmd, and then enter LOAD (cmd=0) or DUMP_RD (cmd=1).
REQ-016 On start in IDLE with word_cnt=0, SHALL go straight to DONE with no SRAM access.
REQ-017 SHALL ignore start in any state other than IDLE.
REQ-018 In LOAD, SHALL drive s_ready=1 combinationally.
REQ-019 In LOAD, each cycle with s_valid&s_ready SHALL issue a write in that cycle: sram_wdata=s_data, sram_addr=current address; sustained rate is 1 word/cycle.
REQ-020 In DUMP_RD, SHALL issue a read (ren=1) for one cycle, capture sram_rdata into m_data on the rising edge ending that cycle, and then enter DUMP_OUT.
REQ-021 In DUMP_OUT, SHALL hold m_valid=1 and m_data stable until m_ready=1; on the handshake it enters DUMP_RD, or DONE after the last word; peak rate is 1 word per 2 cycles.
REQ-022 After each word, SHALL advance the address by BW/8 and wrap modulo 2**ADDR_W; bits 63:ADDR_W of sram_addr SHALL be 0.
REQ-023 In DONE, SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL keep m_valid at 0 outside DUMP_OUT, s_ready at 0 outside LOAD, and the SRAM in idle outside write and read cycles.

Reset
REQ-026 Assertion of arst_n at any time, including mid-transfer, SHALL force IDLE and abandon the transfer with no done pulse.
REQ-027 Under reset, SHALL drive every output to 0: busy, done, s_ready, m_valid, m_data, sram_addr, sram_wen, sram_ren, sram_wdata and checksum.
REQ-028 After deassertion of arst_n, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, SHALL provide output checksum (BW bits): the XOR of all words transferred, cleared on an accepted start and valid from the done cycle onward.
REQ-030 With LOADER_CHECKSUM_EN undefined, the checksum port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 SHALL take its state encoding enum, the CMD_LOAD/CMD_DUMP constants and the SRAM op-encoding constants from the shared package sram_ext_pkg.
REQ-032 SHALL place the address/count generator (latch, increment, wrap, last-word flag) in the sub-module sram_ext_addr_gen; the FSM and datapath stay in the top module.

Verification
REQ-033 Load: base 0x000, cnt 4, data 0xA0..A3 with s_valid held -> four consecutive writes at 0x000, 0x004, 0x008, 0x00C; done pulse in the following cycle.
REQ-034 Dump with backpressure: after the load, dump base 0x004, cnt 2, m_ready low for 3 cycles -> m_data 0xA1 held stable until accepted, then 0xA2; done pulse.
REQ-035 Wrap: ADDR_W=9, BW=32, load base 0x1FC, cnt 2 -> writes at 0x1FC, then 0x000.
REQ-036 Zero count: start with cnt 0 -> done one cycle later, with no wen or ren asserted.
REQ-037 Reset mid-load: arst_n asserted after 2 of 8 words -> all outputs 0 and no done pulse; a new start is then accepted normally.
REQ-038 Checksum: with LOADER_CHECKSUM_EN defined, load 0x0F and 0xF0 -> checksum 0xFF at done; a start during busy is ignored.
